// File: rtl/tt_um_unsigned_recombiner_pkg.sv
// Shared constants and state encoding for the unsigned dividend recombiner.
// The block rebuilds N = Q*D + R from a quotient, divisor and remainder.
package tt_um_unsigned_recombiner_pkg;

    localparam int OPW  = 4;
    localparam int RESW = 2 * OPW;

    localparam logic [RESW-1:0] ERR_VALUE    = 8'hFF;
    localparam logic [7:0]      UIO_OE_VALUE = 8'b1110_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // An operand triple is usable only when the remainder is strictly below a non-zero divisor.
    function automatic logic operandsValid(input logic [OPW-1:0] d, input logic [OPW-1:0] r);
        return (d != '0) && (r < d);
    endfunction

endpackage

// File: rtl/recomb_datapath.sv
// Operand capture, shift-add multiplier and the final remainder add.
// One partial product is accumulated per step, least significant quotient bit first.
module recomb_datapath
    import tt_um_unsigned_recombiner_pkg::*;
#(
    parameter int OPW = tt_um_unsigned_recombiner_pkg::OPW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [OPW-1:0]     i_q,
    input  logic [OPW-1:0]     i_d,
    input  logic [OPW-1:0]     i_r,
    output logic [2*OPW-1:0]   o_sum,
    output logic               o_last
);

    localparam int RW = 2 * OPW;
    localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;

    logic [OPW-1:0] r_q;
    logic [OPW-1:0] r_d;
    logic [OPW-1:0] r_r;
    logic [RW-1:0]  r_acc;
    logic [CW-1:0]  r_cnt;

    logic [RW-1:0]  w_partial;

    // The step counter doubles as the quotient bit index and the divisor shift amount.
    always_comb begin
        w_partial = '0;
        if (r_q[r_cnt]) begin
            w_partial = {{OPW{1'b0}}, r_d} << r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_d   <= '0;
            r_r   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_q   <= i_q;
            r_d   <= i_d;
            r_r   <= i_r;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= r_acc + w_partial;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_sum  = r_acc + {{OPW{1'b0}}, r_r};
    assign o_last = (r_cnt == CW'(OPW - 1));

endmodule

// File: rtl/tt_um_unsigned_recombiner.sv
// Top level: control FSM, operand validation, result registers and pin mapping.
// A start in IDLE captures Q/D/R; valid operands take MUL x4, ADD, DONE, invalid ones jump to DONE with err.
module tt_um_unsigned_recombiner
    import tt_um_unsigned_recombiner_pkg::*;
#(
    parameter int OPW = tt_um_unsigned_recombiner_pkg::OPW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t r_state;
    state_t w_next;

    logic [2*OPW-1:0] r_result;
    logic             r_err;

    logic [OPW-1:0]   w_q;
    logic [OPW-1:0]   w_d;
    logic [OPW-1:0]   w_r;
    logic             w_start;
    logic             w_valid;
    logic             w_load;
    logic             w_step;
    logic             w_finishOk;
    logic             w_finishErr;
    logic [2*OPW-1:0] w_sum;
    logic             w_last;
    logic             w_unused;

    assign w_q      = ui_in[2*OPW-1:OPW];
    assign w_d      = ui_in[OPW-1:0];
    assign w_r      = uio_in[OPW-1:0];
    assign w_start  = uio_in[4];
    assign w_valid  = operandsValid(w_d, w_r);
    assign w_unused = &{1'b0, uio_in[7:5]};

    recomb_datapath #(
        .OPW (OPW)
    ) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_q    (w_q),
        .i_d    (w_d),
        .i_r    (w_r),
        .o_sum  (w_sum),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_next;
        end
    end

    // Every datapath action is qualified by ena so a low enable freezes the whole block.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finishOk  = 1'b0;
        w_finishErr = 1'b0;
        if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        w_load = 1'b1;
                        if (w_valid) begin
                            w_next = ST_MUL;
                        end else begin
                            w_next      = ST_DONE;
                            w_finishErr = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_next = ST_ADD;
                    end
                end
                ST_ADD: begin
                    w_next     = ST_DONE;
                    w_finishOk = 1'b1;
                end
                ST_DONE: begin
                    w_next = ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // The result is loaded on entry to DONE and then held until the next DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_finishErr) begin
            r_result <= ERR_VALUE;
            r_err    <= 1'b1;
        end else if (w_finishOk) begin
            r_result <= w_sum;
            r_err    <= 1'b0;
        end
    end

    assign uo_out  = r_result;
    assign uio_out = {r_err,
                      (r_state == ST_DONE),
                      (r_state == ST_MUL) || (r_state == ST_ADD),
                      5'b0_0000};
    assign uio_oe  = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_unsigned_recombiner.sv
// Scoreboard bench for the recombiner: stimulus queues expected results, a negedge monitor checks each done pulse.
module tb_tt_um_unsigned_recombiner;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;
    int cycleCount;

    typedef struct {
        logic [7:0] n;
        logic       err;
        int         cycle;
        string      name;
    } exp_t;

    exp_t sb[$];

    tt_um_unsigned_recombiner dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkCycle(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s_cycle actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drives one start pulse; expected result arrives lat cycles after the driving negedge.
    task automatic applyStimulus(input logic [3:0] q, input logic [3:0] d, input logic [3:0] r,
                                 input logic [7:0] expN, input logic expErr, input int lat,
                                 input string name, input bit push);
        exp_t e;
        @(negedge clk);
        ui_in  = {q, d};
        uio_in = {3'b000, 1'b1, r};
        if (push) begin
            e.n = expN; e.err = expErr; e.cycle = cycleCount + lat; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        uio_in[4] = 1'b0;
    endtask

    task automatic drainScoreboard(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && ena && uio_out[6]) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0 at cycle %0d", cycleCount);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_n"}, uo_out, e.n);
                checkOutput({e.name, "_err"}, {7'b0, uio_out[7]}, {7'b0, e.err});
                checkCycle(e.name, cycleCount, e.cycle);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ena      = 1'b1;
        ui_in    = 8'h00;
        uio_in   = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_uo_out", uo_out, 8'h00);
        checkOutput("reset_uio_out", uio_out, 8'h00);
        checkOutput("reset_uio_oe", uio_oe, 8'hE0);
        rst = 1'b0;

        // Q=2 D=3 R=1: busy for k+1..k+5, done at k+6
        applyStimulus(4'd2, 4'd3, 4'd1, 8'd7, 1'b0, 6, "basic", 1'b1);
        checkOutput("basic_busy_first", {7'b0, uio_out[5]}, 8'd1);
        repeat (4) @(negedge clk);
        checkOutput("basic_busy_last", {7'b0, uio_out[5]}, 8'd1);
        @(negedge clk);
        checkOutput("basic_busy_done", {7'b0, uio_out[5]}, 8'd0);
        drainScoreboard("basic");
        checkOutput("hold_uo_out", uo_out, 8'd7);
        checkOutput("hold_flags", uio_out, 8'h00);

        applyStimulus(4'd15, 4'd15, 4'd14, 8'd239, 1'b0, 6, "max", 1'b1);
        drainScoreboard("max");

        applyStimulus(4'd7, 4'd0, 4'd3, 8'hFF, 1'b1, 1, "div_zero", 1'b1);
        checkOutput("div_zero_busy", {7'b0, uio_out[5]}, 8'd0);
        drainScoreboard("div_zero");

        applyStimulus(4'd9, 4'd5, 4'd5, 8'hFF, 1'b1, 1, "rem_eq_div", 1'b1);
        checkOutput("rem_eq_div_busy", {7'b0, uio_out[5]}, 8'd0);
        drainScoreboard("rem_eq_div");

        // Second start during MUL with different operands must be ignored
        applyStimulus(4'd3, 4'd5, 4'd2, 8'd17, 1'b0, 6, "ignore_start", 1'b1);
        @(negedge clk);
        ui_in  = {4'd9, 4'd9};
        uio_in = {3'b000, 1'b1, 4'd0};
        @(negedge clk);
        uio_in[4] = 1'b0;
        drainScoreboard("ignore_start");

        // Reset during MUL aborts without a done pulse
        applyStimulus(4'd6, 4'd7, 4'd2, 8'd0, 1'b0, 0, "abort", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_uo_out", uo_out, 8'h00);
        checkOutput("abort_uio_out", uio_out, 8'h00);
        rst = 1'b0;
        applyStimulus(4'd4, 4'd4, 4'd3, 8'd19, 1'b0, 6, "after_reset", 1'b1);
        drainScoreboard("after_reset");

        // Three frozen cycles during MUL delay done by three
        applyStimulus(4'd5, 4'd6, 4'd4, 8'd34, 1'b0, 9, "stall", 1'b1);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stall_busy", {7'b0, uio_out[5]}, 8'd1);
        ena = 1'b1;
        drainScoreboard("stall");

        // Held start re-triggers with a 7-cycle period
        @(negedge clk);
        ui_in  = {4'd1, 4'd1};
        uio_in = {3'b000, 1'b1, 4'd0};
        sb.push_back('{8'd1, 1'b0, cycleCount + 6, "held_first"});
        sb.push_back('{8'd1, 1'b0, cycleCount + 13, "held_second"});
        repeat (8) @(negedge clk);
        uio_in[4] = 1'b0;
        drainScoreboard("held");
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_unsigned_recombiner.md
TT_UM_UNSIGNED_RECOMBINER -- requirements
Module: tt_um_unsigned_recombiner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: "clk" (rising edge) and "rst", both 1-bit inputs.
REQ-002 Parameter: OPW, default 4, operand width in bits; only 4 is supported by the pin map.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ena  input  1  design enable; low freezes all state.
REQ-006 ui_in  input  8  [7:4] quotient Q, [3:0] divisor D.
REQ-007 uio_in  input  8  [3:0] remainder R, [4] start; [7:5] ignored.
REQ-008 uo_out  output  8  reconstructed dividend N.
REQ-009 uio_out  output  8  [5] busy, [6] done, [7] err; [4:0] driven 0.
REQ-010 uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-011 The block SHALL compute N = Q*D + R, unsigned, 8-bit result; no overflow is possible (max 15*15+14 = 239).
REQ-012 States SHALL be IDLE, MUL, ADD, DONE.
REQ-013 In IDLE with ena=1 and start=1 at edge k, the block SHALL capture Q, D and R into internal registers and validate them.
REQ-014 If the captured D == 0 or R >= D, the block SHALL go to DONE at k+1 with err=1 and uo_out=8'hFF (MUL and ADD are skipped).
REQ-015 Otherwise the block SHALL enter MUL and perform one shift-add step per cycle, LSB of Q first, using a 2-bit step counter 0..3; MUL lasts exactly 4 cycles (k+1..k+4).
REQ-016 ADD SHALL occupy cycle k+5 and add the zero-extended R to the accumulated product.
REQ-017 DONE SHALL occupy cycle k+6, with uo_out=N, err=0 and done=1.
REQ-018 done SHALL be high for exactly one enabled cycle (DONE), after which the block returns to IDLE.
REQ-019 busy SHALL be 1 in MUL and ADD, and 0 in IDLE and DONE.
REQ-020 uo_out and err SHALL hold their last value from DONE until the next DONE.
REQ-021 start SHALL be level-sensitive and accepted only in IDLE; start in MUL, ADD or DONE SHALL be ignored.
REQ-022 A start held high SHALL re-trigger on the first IDLE cycle after DONE (operation period 7 cycles).
REQ-023 Input changes after capture SHALL NOT affect the operation in progress.
REQ-024 With ena=0, state, counter, datapath and outputs SHALL hold; done SHALL stay asserted if frozen in DONE.

Reset
REQ-025 With rst=1 at a clock edge, regardless of state or ena, the block SHALL set state to IDLE, counter to 0, and uo_out, busy, done and err to 0; internal operand registers SHALL clear to 0.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse; a new start is accepted on the first edge with rst=0.

Structure
REQ-027 A shared package SHALL hold the state encoding (2-bit), OPW, the result width (2*OPW), the error value 8'hFF and the uio_oe constant.
REQ-028 The shift-add accumulator and counter SHALL be one sub-module, recomb_datapath; the top holds the FSM, the validation and the pin mapping.

Verification
REQ-029 Q=2, D=3, R=1, start pulse -> busy for cycles k+1..k+5, done at k+6, uo_out=8'd7, err=0.
REQ-030 Q=15, D=15, R=14 -> uo_out=8'd239 (8'hEF) at k+6, err=0.
REQ-031 D=0 (any Q, R) -> done at k+1, uo_out=8'hFF, err=1, busy never asserted; R=5, D=5 -> same response.
REQ-032 Start in IDLE, then change operands and pulse start at k+2 -> the second start is ignored and the result uses the first operands only.
REQ-033 rst=1 at k+3 during MUL -> all outputs 0 at k+4, no done pulse; a new start with Q=4, D=4, R=3 -> uo_out=8'd19.
REQ-034 ena=0 for 3 cycles during MUL -> done is delayed by exactly 3 cycles and the result is unchanged.
